// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding requests to a
// variable-latency instruction memory and loads the IF/ID register under stall/flush.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_write,
  input  logic        IF_ID_write,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_IF_ID,
  output logic [31:0] pc_plus4_IF_ID,
  output logic [31:0] instr_IF_ID,
  output logic        valid_IF_ID
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        vld;
  } ifid_t;

  state_t      state, nstate;
  logic [31:0] pc, hold_buf;
  ifid_t       ifid;
  logic        advance, deliver, use_buf, cap;

  assign advance = PC_write && IF_ID_write;

  // rst_n gating keeps the request low for the whole reset window
  assign imem_req  = rst_n && (state == S_FETCH);
  assign imem_addr = pc;

  always_comb begin
    nstate  = state;
    deliver = 1'b0;
    use_buf = 1'b0;
    cap     = 1'b0;
    case (state)
      S_FETCH: begin
        if (flush)           nstate = imem_ready ? S_DROP : S_FETCH;
        else if (imem_ready) nstate = S_WAIT;
      end
      S_WAIT: begin
        if (flush) nstate = imem_rvalid ? S_FETCH : S_DROP;
        else if (imem_rvalid) begin
          if (advance) begin
            nstate  = S_FETCH;
            deliver = 1'b1;
          end else begin
            nstate = S_HOLD;
            cap    = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (flush) nstate = S_FETCH;
        else if (advance) begin
          nstate  = S_FETCH;
          deliver = 1'b1;
          use_buf = 1'b1;
        end
      end
      S_DROP: begin
        // the stale response retires the outstanding request even under flush
        if (imem_rvalid) nstate = S_FETCH;
      end
      default: nstate = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= nstate;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (flush)   pc <= branch_target;
    else if (deliver) pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   hold_buf <= '0;
    else if (cap) hold_buf <= imem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ifid <= '0;
    else if (flush) begin
      ifid.vld   <= 1'b0;
      ifid.instr <= '0;
    end else if (deliver) begin
      ifid.pc    <= pc;
      ifid.pc4   <= pc + 32'd4;
      ifid.instr <= use_buf ? hold_buf : imem_rdata;
      ifid.vld   <= 1'b1;
    end else if (advance) begin
      ifid.vld   <= 1'b0;
      ifid.instr <= '0;
    end
  end

  assign pc_IF_ID       = ifid.pc;
  assign pc_plus4_IF_ID = ifid.pc4;
  assign instr_IF_ID    = ifid.instr;
  assign valid_IF_ID    = ifid.vld;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: transaction-level model of the fetch stage
// plus a single-outstanding memory responder, with directed scenarios up front.
module tb_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        PC_write = 1'b1, IF_ID_write = 1'b1, flush = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req, imem_ready = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic [31:0] pc_IF_ID, pc_plus4_IF_ID, instr_IF_ID;
  logic        valid_IF_ID;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
    .flush(flush), .branch_target(branch_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .pc_IF_ID(pc_IF_ID), .pc_plus4_IF_ID(pc_plus4_IF_ID),
    .instr_IF_ID(instr_IF_ID), .valid_IF_ID(valid_IF_ID)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  // model: request outstanding / stale outstanding / buffered word
  logic [31:0] m_pc, m_buf, m_pcid, m_pc4, m_ins;
  logic        m_out, m_stale, m_bufv, m_vld;
  logic        mem_pend;
  int          mem_dly;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_buf = '0; m_pcid = '0; m_pc4 = '0; m_ins = '0;
    m_out = 0; m_stale = 0; m_bufv = 0; m_vld = 0;
    mem_pend = 0; mem_dly = 0;
  endtask

  task automatic check_all();
    logic idle;
    idle = !m_out && !m_stale && !m_bufv;
    chk("imem_req", {31'b0, imem_req}, {31'b0, idle});
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_IF_ID", pc_IF_ID, m_pcid);
    chk("pc_plus4_IF_ID", pc_plus4_IF_ID, m_pc4);
    chk("instr_IF_ID", instr_IF_ID, m_ins);
    chk("valid_IF_ID", {31'b0, valid_IF_ID}, {31'b0, m_vld});
  endtask

  // Called in the low phase: drive, take one rising edge, update model, check.
  task automatic step(input logic pw, input logic iw, input logic fl, input logic [31:0] bt,
                      input logic rdy, input logic rv, input logic [31:0] rd);
    logic idle, adv, got_v;
    logic [31:0] got;
    PC_write = pw; IF_ID_write = iw; flush = fl; branch_target = bt;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    @(posedge clk);
    idle = !m_out && !m_stale && !m_bufv;
    adv = pw && iw;
    got_v = 0; got = '0;
    if (rv && mem_pend) mem_pend = 0;
    if (idle && rdy) begin mem_pend = 1; mem_dly = $urandom_range(0, 2); end
    if (fl) begin
      if (idle) begin if (rdy) m_stale = 1; end
      else if (m_out) begin m_out = 0; if (!rv) m_stale = 1; end
      else if (m_bufv) m_bufv = 0;
      else if (rv) m_stale = 0;
      m_pc = bt; m_vld = 0; m_ins = '0;
    end else begin
      if (idle) begin if (rdy) m_out = 1; end
      else if (m_stale) begin if (rv) m_stale = 0; end
      else if (m_out) begin
        if (rv) begin
          m_out = 0;
          if (adv) begin got_v = 1; got = rd; end
          else begin m_bufv = 1; m_buf = rd; end
        end
      end else if (adv) begin m_bufv = 0; got_v = 1; got = m_buf; end
      if (got_v) begin
        m_pcid = m_pc; m_pc4 = m_pc + 32'd4; m_ins = got; m_vld = 1; m_pc = m_pc + 32'd4;
      end else if (adv) begin
        m_vld = 0; m_ins = '0;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic pw, iw, fl, rv;
    logic [31:0] bt, rd;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_IF_ID}, 32'd0);
    chk("rst_instr", instr_IF_ID, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST_PC);

    // first fetch
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 32'h2002_0005);
    chk("fetch_pc", pc_IF_ID, 32'h100);
    chk("fetch_pc4", pc_plus4_IF_ID, 32'h104);
    chk("fetch_instr", instr_IF_ID, 32'h2002_0005);
    chk("fetch_next_addr", imem_addr, 32'h104);
    // load-use stall while response arrives
    step(1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 32'h1111_2222);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("stall_hold_pc", pc_IF_ID, 32'h100);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("stall_release_instr", instr_IF_ID, 32'h1111_2222);
    chk("stall_release_addr", imem_addr, 32'h108);
    // flush while waiting, stale response three cycles later
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 32'h400, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("stale_valid", {31'b0, valid_IF_ID}, 32'd0);
    chk("flush_addr", imem_addr, 32'h400);
    // flush with concurrent response
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 1, 32'h400, 0, 1, 32'hBAD0_0000);
    chk("flush_rv_req", {31'b0, imem_req}, 32'd1);
    chk("flush_rv_addr", imem_addr, 32'h400);
    // wrap-around
    step(1, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
    step(1, 1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 1, 32'h0000_0042);
    chk("wrap_pc4", pc_plus4_IF_ID, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        // async reset mid-operation; a leftover response then lands in FETCH
        step(1, 1, 0, 0, 1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'b0, imem_req}, 32'd0);
        chk("midrst_valid", {31'b0, valid_IF_ID}, 32'd0);
        chk("midrst_pc", pc_IF_ID, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        step(1, 1, 0, 0, 0, 1, 32'h5555_AAAA);
        chk("postrst_addr", imem_addr, RST_PC);
        chk("postrst_valid", {31'b0, valid_IF_ID}, 32'd0);
      end
      pw = ($urandom_range(0, 5) != 0);
      iw = ($urandom_range(0, 5) != 0);
      fl = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0: bt = 32'h400;
        1: bt = 32'hFFFF_FFFC;
        default: bt = $urandom;
      endcase
      rd = $urandom;
      rv = 1'b0;
      if (mem_pend) begin
        if (mem_dly == 0) rv = 1'b1;
        else mem_dly--;
      end else begin
        rv = ($urandom_range(0, 19) == 0);
      end
      step(pw, iw, fl, bt, ($urandom_range(0, 9) < 7), rv, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
